// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader
// Boot-time instruction loader: takes a length-prefixed byte stream,
// assembles little-endian 32-bit words and writes them into instruction
// memory, holding the core in reset until the full image is written.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  // Largest legal image, in words: exactly fills the memory.
  localparam int unsigned CAP = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   n_q;        // image length in words
  logic [ADDR_W:0]   cnt_q;      // words written so far
  logic [ADDR_W-1:0] addr_q;     // word address of the word being assembled
  logic [1:0]        k_q;        // byte lane of the next accepted byte
  logic [31:0]       data_q;     // word under assembly
  logic              ready_q;
  logic              wr_en_q;
  logic              done_q;
  logic              err_q;
  logic              core_rst_q;

  logic [ADDR_W:0]   cnt_inc;
  logic              len_bad;

  assign cnt_inc = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
  // Zero words is meaningless, more than CAP would wrap the address.
  assign len_bad = (byte_data == 8'd0) || (32'(byte_data) > CAP);

  // Loader FSM: state, counters, word assembly and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      k_q        <= 2'd0;
      data_q     <= 32'd0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q    <= LEN;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b0;
          end
        end
        LEN: begin
          if (byte_valid) begin
            if (len_bad) begin
              state_q <= ERR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= DATA;
              n_q     <= (ADDR_W+1)'(byte_data);
              cnt_q   <= '0;
              addr_q  <= '0;
              k_q     <= 2'd0;
            end
          end
        end
        DATA: begin
          if (byte_valid) begin
            data_q[{k_q, 3'b000} +: 8] <= byte_data;
            if (k_q == 2'd3) begin
              state_q <= WRITE;
              ready_q <= 1'b0;
              wr_en_q <= 1'b1;
            end else begin
              k_q <= k_q + 2'd1;
            end
          end
        end
        WRITE: begin
          wr_en_q <= 1'b0;
          k_q     <= 2'd0;
          cnt_q   <= cnt_inc;
          if (cnt_inc == n_q) begin
            // Address is left on the last word so it never wraps past the top.
            state_q    <= DONE;
            done_q     <= 1'b1;
            core_rst_q <= 1'b1;
          end else begin
            state_q <= DATA;
            addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader
// Directed self-checking bench for imem_loader with hand-computed vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stim[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic        prev_wr_en = 1'b0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Capture every write; the write cycle must stall the stream and last one cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && wr_en === 1'b1) begin
      wa.push_back(32'(wr_addr));
      wd.push_back(wr_data);
      check("wr_ready_low", 32'(byte_ready), 32'd0);
      if (prev_wr_en) check("wr_single_cycle", 32'(prev_wr_en), 32'd0);
    end
    prev_wr_en <= wr_en;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      start      = 1'b0;
    end
  endtask

  // Pulse start for one edge; the loader should be ready the cycle after.
  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_ready"}, 32'(byte_ready), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_corerst"}, 32'(core_rst), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Offer stim[] bytes; returns on the negedge before the last byte's accepting edge.
  task automatic send(input bit toggle, input bit hold_start);
    int  i   = 0;
    int  cyc = 0;
    bit  ph  = 1'b0;
    while (i < stim.size() && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start      = hold_start;
      ph         = toggle ? ~ph : 1'b1;
      byte_valid = ph;
      byte_data  = ph ? stim[i] : 8'hFF;
      if (ph && byte_ready) i++;
    end
    check("bytes_sent", 32'(i), 32'(stim.size()));
  endtask

  task automatic clear_writes();
    wa.delete();
    wd.delete();
  endtask

  task automatic load_two_word_image();
    stim = '{8'h02, 8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_a0"}, wa[0], 32'd0);
      check({tag, "_d0"}, wd[0], 32'h00500513);
      check({tag, "_a1"}, wa[1], 32'd1);
      check({tag, "_d1"}, wd[1], 32'h00B505B3);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_corerst"}, 32'(core_rst), 32'd1);
    check({tag, "_wc"}, 32'(word_count), 32'd2);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_wren", 32'(wr_en), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_corerst", 32'(core_rst), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    rst = 1'b1;
    idle(1);
    check("idle_ready", 32'(byte_ready), 32'd0);

    // Two-word image, valid always high
    clear_writes();
    do_start("t1_start");
    load_two_word_image();
    send(1'b0, 1'b0);
    idle(1);
    check("t1_last_wren", 32'(wr_en), 32'd1);
    check("t1_done_early", 32'(done), 32'd0);
    idle(1);
    check_two_word("t1");
    idle(2);
    check("t1_no_extra_wr", 32'(wa.size()), 32'd2);

    // Restart from DONE; valid toggling, start held during the stream
    clear_writes();
    do_start("t2_start");
    load_two_word_image();
    send(1'b1, 1'b1);
    idle(2);
    check_two_word("t2");

    // Bad headers, bytes ignored in ERR, then recovery
    clear_writes();
    do_start("t3_start");
    stim = '{8'h00};
    send(1'b0, 1'b0);
    idle(1);
    check("t3_err0", 32'(err), 32'd1);
    check("t3_err0_corerst", 32'(core_rst), 32'd0);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    check("t3_err_ready", 32'(byte_ready), 32'd0);
    idle(1);
    do_start("t3_restart");
    stim = '{8'h41};
    send(1'b0, 1'b0);
    idle(1);
    check("t3_err41", 32'(err), 32'd1);
    check("t3_nwr", 32'(wa.size()), 32'd0);
    do_start("t3_recover");
    stim = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    send(1'b0, 1'b0);
    idle(2);
    check("t3_rec_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("t3_rec_a0", wa[0], 32'd0);
      check("t3_rec_d0", wd[0], 32'h12345678);
    end
    check("t3_rec_done", 32'(done), 32'd1);
    check("t3_rec_err", 32'(err), 32'd0);
    check("t3_rec_wc", 32'(word_count), 32'd1);

    // Full memory: 64 words, byte value = stream position
    clear_writes();
    do_start("t4_start");
    stim.delete();
    stim.push_back(8'h40);
    for (int i = 0; i < 256; i++) stim.push_back(i[7:0]);
    send(1'b0, 1'b0);
    idle(2);
    check("t4_nwr", 32'(wa.size()), 32'd64);
    if (wa.size() == 64) begin
      for (int j = 0; j < 64; j++) begin
        logic [7:0] b0;
        b0 = 8'(4 * j);
        check($sformatf("t4_a%0d", j), wa[j], 32'(j));
        check($sformatf("t4_d%0d", j), wd[j], {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
      end
    end
    check("t4_done", 32'(done), 32'd1);
    check("t4_wc", 32'(word_count), 32'd64);

    // Reset after 2 bytes of word 1
    clear_writes();
    do_start("t5_start");
    stim = '{8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    send(1'b0, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t5_ready", 32'(byte_ready), 32'd0);
    check("t5_wren", 32'(wr_en), 32'd0);
    check("t5_addr", 32'(wr_addr), 32'd0);
    check("t5_data", wr_data, 32'd0);
    check("t5_corerst", 32'(core_rst), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_wc", 32'(word_count), 32'd0);
    idle(4);
    check("t5_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) check("t5_d0", wd[0], 32'hA4A3A2A1);
    clear_writes();
    do_start("t5_restart");
    stim = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send(1'b0, 1'b0);
    idle(2);
    check("t5_rec_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("t5_rec_a0", wa[0], 32'd0);
      check("t5_rec_d0", wd[0], 32'h44332211);
    end
    check("t5_rec_done", 32'(done), 32'd1);
    check("t5_rec_wc", 32'(word_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
